// File: rtl/avalon_pio_out_bank.sv
// avalon_pio_out_bank
//   Avalon-MM slave output-port bank for the Nios II bus. The CPU writes NUM_CH
//   shadow registers. A commit copies all of them at once into the live
//   out_port registers. A valid/ready handshake then presents the new snapshot
//   to the downstream consumer.
//
// Ports
//   clk, reset_n     clock, asynchronous active-low reset
//   address          word address (SHADOW 0..NUM_CH-1, CTRL NUM_CH, STATUS NUM_CH+1)
//   chipselect       slave select
//   write_n          active-low write strobe
//   writedata        write data
//   byteenable       per-byte write enables (only with PIO_BYTEENABLE_EN)
//   readdata         combinational read data, zero wait states
//   out_port         live registers, channel i = bits [i*DATA_W +: DATA_W]
//   out_valid        a new live snapshot is presented
//   out_ready        consumer accepts the snapshot
//
// Build option
//   PIO_BYTEENABLE_EN  adds the byteenable port. SHADOW and CTRL writes then
//                      update only the enabled byte lanes. A CTRL commit also
//                      needs byteenable[0].
module avalon_pio_out_bank #(
    parameter int          DATA_W    = 32,
    parameter int          NUM_CH    = 4,
    parameter int          ADDR_W    = 4,
    parameter logic [31:0] RESET_VAL = 32'h61906400
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic [ADDR_W-1:0]        address,
    input  logic                     chipselect,
    input  logic                     write_n,
    input  logic [DATA_W-1:0]        writedata,
`ifdef PIO_BYTEENABLE_EN
    input  logic [DATA_W/8-1:0]      byteenable,
`endif
    output logic [DATA_W-1:0]        readdata,
    output logic [NUM_CH*DATA_W-1:0] out_port,
    output logic                     out_valid,
    input  logic                     out_ready
);

    localparam logic [DATA_W-1:0] RST_WORD    = DATA_W'(RESET_VAL);
    localparam logic [ADDR_W-1:0] CTRL_ADDR   = ADDR_W'(NUM_CH);
    localparam logic [ADDR_W-1:0] STATUS_ADDR = ADDR_W'(NUM_CH + 1);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_WAIT} state_t;

    state_t            state, next_state;
    logic [DATA_W-1:0] shadow [NUM_CH];
    logic [DATA_W-1:0] live   [NUM_CH];
    logic              auto_commit;
    logic              pending;
    logic              load_live;

    logic              wr;
    logic              ctrl_wr;
    logic [NUM_CH-1:0] shadow_wr;
    logic [DATA_W-1:0] wr_mask;
    logic              cr;
    logic              busy;

    assign wr      = chipselect & ~write_n;
    assign ctrl_wr = wr && (address == CTRL_ADDR);
    assign busy    = (state != S_IDLE);

    always_comb begin
        shadow_wr = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (wr && (address == ADDR_W'(i))) begin
                shadow_wr[i] = 1'b1;
            end
        end
    end

    // Bit mask of the lanes a write may touch. Without byte enables every
    // write covers the whole word.
    always_comb begin
        wr_mask = '1;
`ifdef PIO_BYTEENABLE_EN
        for (int b = 0; b < DATA_W/8; b++) begin
            wr_mask[b*8 +: 8] = {8{byteenable[b]}};
        end
`endif
    end

    // Both CTRL bits live in byte lane 0, so the lane-0 mask gates them.
    assign cr = (ctrl_wr & writedata[0] & wr_mask[0]) | ((|shadow_wr) & auto_commit);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_CH; i++) begin
                shadow[i] <= RST_WORD;
            end
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (shadow_wr[i]) begin
                    shadow[i] <= (shadow[i] & ~wr_mask) | (writedata & wr_mask);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            auto_commit <= 1'b0;
        end else if (ctrl_wr && wr_mask[0]) begin
            auto_commit <= writedata[1];
        end
    end

    // pending also serves as the request latch from IDLE. A request first
    // registers here, and the FSM leaves IDLE one cycle later. LOAD then
    // samples the shadows on its exit edge. This fixes the latency at two
    // edges and lets a shadow write on the edge after the commit still land
    // in the snapshot. A request that arrives together with out_ready in
    // WAIT is kept the same way and reaches LOAD through one IDLE cycle. A
    // new request wins over the clear that happens on LOAD entry.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pending <= 1'b0;
        end else begin
            pending <= cr | (pending & (next_state != S_LOAD));
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        load_live  = 1'b0;
        case (state)
            S_IDLE: begin
                if (pending) begin
                    next_state = S_LOAD;
                end
            end
            S_LOAD: begin
                load_live  = 1'b1;
                next_state = S_WAIT;
            end
            S_WAIT: begin
                if (out_ready) begin
                    next_state = pending ? S_LOAD : S_IDLE;
                end
            end
            default: next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_valid <= 1'b0;
        end else if (load_live) begin
            out_valid <= 1'b1;
        end else if ((state == S_WAIT) && out_ready) begin
            out_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_CH; i++) begin
                live[i] <= RST_WORD;
            end
        end else if (load_live) begin
            for (int i = 0; i < NUM_CH; i++) begin
                live[i] <= shadow[i];
            end
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_out
        assign out_port[g*DATA_W +: DATA_W] = live[g];
    end

    // The commit bit is self-clearing, so CTRL reads back only auto_commit.
    always_comb begin
        readdata = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (address == ADDR_W'(i)) begin
                readdata = shadow[i];
            end
        end
        if (address == CTRL_ADDR) begin
            readdata = DATA_W'({auto_commit, 1'b0});
        end
        if (address == STATUS_ADDR) begin
            readdata = DATA_W'({busy, pending, out_valid});
        end
    end

endmodule

// File: tb/tb_avalon_pio_out_bank.sv
// tb_avalon_pio_out_bank
//   Directed self-checking bench for avalon_pio_out_bank with the default
//   parameters (4 channels of 32 bits, CTRL at 4, STATUS at 5).
module tb_avalon_pio_out_bank;

    localparam logic [31:0] RV = 32'h61906400;

    logic         clk = 1'b0;
    logic         reset_n;
    logic [3:0]   address;
    logic         chipselect;
    logic         write_n;
    logic [31:0]  writedata;
    logic [31:0]  readdata;
    logic [127:0] out_port;
    logic         out_valid;
    logic         out_ready;
`ifdef PIO_BYTEENABLE_EN
    logic [3:0]   be;
`endif

    int tests_run    = 0;
    int tests_failed = 0;

    avalon_pio_out_bank dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
`ifdef PIO_BYTEENABLE_EN
        .byteenable (be),
`endif
        .readdata   (readdata),
        .out_port   (out_port),
        .out_valid  (out_valid),
        .out_ready  (out_ready)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic bus_write(input logic [3:0] a, input logic [31:0] d);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        @(posedge clk);
        #1;
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    task automatic bus_read(input logic [3:0] a, output logic [31:0] d);
        address    = a;
        chipselect = 1'b1;
        write_n    = 1'b1;
        #1;
        d          = readdata;
        chipselect = 1'b0;
    endtask

    task automatic test_reset;
        logic [31:0] rd;
        tests_run++;
        if (out_port !== {4{RV}}) begin
            tests_failed++;
            $display("[TB] FAIL reset_out_port: got %h expected %h", out_port, {4{RV}});
        end
        tests_run++;
        if (out_valid !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL reset_out_valid: got %b expected 0", out_valid);
        end
        bus_read(4'd5, rd);
        tests_run++;
        if (rd !== 32'h0) begin
            tests_failed++;
            $display("[TB] FAIL reset_status: got %h expected 00000000", rd);
        end
        bus_read(4'd2, rd);
        tests_run++;
        if (rd !== RV) begin
            tests_failed++;
            $display("[TB] FAIL reset_shadow2: got %h expected %h", rd, RV);
        end
    endtask

    task automatic test_commit;
        out_ready = 1'b1;
        bus_write(4'd1, 32'hDEADBEEF);
        bus_write(4'd4, 32'h1);
        tick(1);
        tests_run++;
        if (out_valid !== 1'b0 || out_port[63:32] !== RV) begin
            tests_failed++;
            $display("[TB] FAIL commit_early: valid %b ch1 %h, expected 0 and %h", out_valid, out_port[63:32], RV);
        end
        tick(1);
        tests_run++;
        if (out_valid !== 1'b1 || out_port[63:32] !== 32'hDEADBEEF || out_port[31:0] !== RV) begin
            tests_failed++;
            $display("[TB] FAIL commit_snapshot: valid %b ch1 %h ch0 %h, expected 1 deadbeef %h", out_valid, out_port[63:32], out_port[31:0], RV);
        end
        tick(1);
        tests_run++;
        if (out_valid !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL commit_one_cycle: valid %b expected 0", out_valid);
        end
    endtask

    task automatic test_snapshot_window;
        out_ready = 1'b1;
        bus_write(4'd4, 32'h1);
        bus_write(4'd3, 32'h00000033);
        tick(1);
        tests_run++;
        if (out_valid !== 1'b1 || out_port[127:96] !== 32'h33) begin
            tests_failed++;
            $display("[TB] FAIL snapshot_window: valid %b ch3 %h, expected 1 00000033", out_valid, out_port[127:96]);
        end
        tick(2);
    endtask

    task automatic test_pending;
        logic [31:0] rd;
        out_ready = 1'b0;
        bus_write(4'd0, 32'h000000AA);
        bus_write(4'd4, 32'h1);
        tick(2);
        tests_run++;
        if (out_valid !== 1'b1 || out_port[31:0] !== 32'hAA) begin
            tests_failed++;
            $display("[TB] FAIL pending_first: valid %b ch0 %h, expected 1 000000aa", out_valid, out_port[31:0]);
        end
        bus_write(4'd0, 32'h5);
        bus_write(4'd4, 32'h1);
        bus_write(4'd4, 32'h1);
        bus_read(4'd5, rd);
        tests_run++;
        if (rd !== 32'h7) begin
            tests_failed++;
            $display("[TB] FAIL pending_status: got %h expected 00000007", rd);
        end
        bus_read(4'd0, rd);
        tests_run++;
        if (rd !== 32'h5 || out_port[31:0] !== 32'hAA || out_valid !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL pending_hold: shadow0 %h live0 %h valid %b, expected 5 aa 1", rd, out_port[31:0], out_valid);
        end
        out_ready = 1'b1;
        tick(1);
        tests_run++;
        if (out_valid !== 1'b0 || out_port[31:0] !== 32'hAA) begin
            tests_failed++;
            $display("[TB] FAIL pending_ack: valid %b ch0 %h, expected 0 000000aa", out_valid, out_port[31:0]);
        end
        tick(1);
        tests_run++;
        if (out_valid !== 1'b1 || out_port[31:0] !== 32'h5) begin
            tests_failed++;
            $display("[TB] FAIL pending_second: valid %b ch0 %h, expected 1 00000005", out_valid, out_port[31:0]);
        end
        tick(3);
        bus_read(4'd5, rd);
        tests_run++;
        if (out_valid !== 1'b0 || rd !== 32'h0) begin
            tests_failed++;
            $display("[TB] FAIL pending_idle: valid %b status %h, expected 0 00000000", out_valid, rd);
        end
    endtask

    task automatic test_auto_commit;
        logic [31:0] rd;
        int          valid_cycles;
        out_ready = 1'b1;
        bus_write(4'd4, 32'h2);
        bus_read(4'd4, rd);
        tests_run++;
        if (rd !== 32'h2) begin
            tests_failed++;
            $display("[TB] FAIL auto_ctrl_read: got %h expected 00000002", rd);
        end
        bus_write(4'd2, 32'h7);
        tick(2);
        tests_run++;
        if (out_valid !== 1'b1 || out_port[95:64] !== 32'h7) begin
            tests_failed++;
            $display("[TB] FAIL auto_snapshot: valid %b ch2 %h, expected 1 00000007", out_valid, out_port[95:64]);
        end
        tick(2);
        bus_write(4'd4, 32'h0);
        bus_write(4'd2, 32'h8);
        valid_cycles = 0;
        for (int i = 0; i < 5; i++) begin
            tick(1);
            if (out_valid === 1'b1) valid_cycles++;
        end
        tests_run++;
        if (valid_cycles !== 0 || out_port[95:64] !== 32'h7) begin
            tests_failed++;
            $display("[TB] FAIL auto_off: valid cycles %0d ch2 %h, expected 0 00000007", valid_cycles, out_port[95:64]);
        end
    endtask

    task automatic test_ready_same_cycle;
        int valid_cycles;
        out_ready = 1'b0;
        bus_write(4'd4, 32'h1);
        tick(2);
        bus_write(4'd1, 32'h00001111);
        out_ready = 1'b1;
        bus_write(4'd4, 32'h1);
        tests_run++;
        if (out_valid !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL same_cycle_ack: valid %b expected 0", out_valid);
        end
        valid_cycles = 0;
        for (int i = 0; i < 6; i++) begin
            tick(1);
            if (out_valid === 1'b1) valid_cycles++;
        end
        tests_run++;
        if (valid_cycles !== 1 || out_port[63:32] !== 32'h1111 || out_port[95:64] !== 32'h8) begin
            tests_failed++;
            $display("[TB] FAIL same_cycle_request: valid cycles %0d ch1 %h ch2 %h, expected 1 00001111 00000008", valid_cycles, out_port[63:32], out_port[95:64]);
        end
    endtask

    task automatic test_unmapped;
        logic [31:0] rd;
        logic [31:0] s0, s1, s2, s3, c;
        int          valid_cycles;
        bus_read(4'd7, rd);
        tests_run++;
        if (rd !== 32'h0) begin
            tests_failed++;
            $display("[TB] FAIL unmapped_read: got %h expected 00000000", rd);
        end
        bus_write(4'd7, 32'hFFFFFFFF);
        valid_cycles = 0;
        for (int i = 0; i < 4; i++) begin
            tick(1);
            if (out_valid === 1'b1) valid_cycles++;
        end
        bus_read(4'd0, s0);
        bus_read(4'd1, s1);
        bus_read(4'd2, s2);
        bus_read(4'd3, s3);
        bus_read(4'd4, c);
        tests_run++;
        if (s0 !== 32'h5 || s1 !== 32'h1111 || s2 !== 32'h8 || s3 !== 32'h33 || c !== 32'h0 || valid_cycles !== 0) begin
            tests_failed++;
            $display("[TB] FAIL unmapped_write: shadows %h %h %h %h ctrl %h valid cycles %0d, expected 5 1111 8 33 0 0", s0, s1, s2, s3, c, valid_cycles);
        end
    endtask

    task automatic test_reset_mid;
        logic [31:0] rd;
        int          valid_cycles;
        out_ready = 1'b0;
        bus_write(4'd4, 32'h1);
        tick(2);
        tests_run++;
        if (out_valid !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL reset_mid_setup: valid %b expected 1", out_valid);
        end
        reset_n = 1'b0;
        #1;
        tests_run++;
        if (out_valid !== 1'b0 || out_port !== {4{RV}}) begin
            tests_failed++;
            $display("[TB] FAIL reset_mid_abort: valid %b port %h, expected 0 %h", out_valid, out_port, {4{RV}});
        end
        tick(1);
        reset_n   = 1'b1;
        out_ready = 1'b1;
        valid_cycles = 0;
        for (int i = 0; i < 5; i++) begin
            tick(1);
            if (out_valid === 1'b1) valid_cycles++;
        end
        bus_read(4'd0, rd);
        tests_run++;
        if (valid_cycles !== 0 || rd !== RV) begin
            tests_failed++;
            $display("[TB] FAIL reset_mid_release: valid cycles %0d shadow0 %h, expected 0 %h", valid_cycles, rd, RV);
        end
    endtask

`ifdef PIO_BYTEENABLE_EN
    task automatic test_byteenable;
        logic [31:0] rd;
        int          valid_cycles;
        be = 4'b0010;
        bus_write(4'd0, 32'hFFFFFFFF);
        be = 4'b1111;
        bus_read(4'd0, rd);
        tests_run++;
        if (rd !== 32'h6190FF00) begin
            tests_failed++;
            $display("[TB] FAIL byteenable_shadow: got %h expected 6190ff00", rd);
        end
        be = 4'b1110;
        bus_write(4'd4, 32'h3);
        be = 4'b1111;
        valid_cycles = 0;
        for (int i = 0; i < 4; i++) begin
            tick(1);
            if (out_valid === 1'b1) valid_cycles++;
        end
        bus_read(4'd4, rd);
        tests_run++;
        if (valid_cycles !== 0 || rd !== 32'h0) begin
            tests_failed++;
            $display("[TB] FAIL byteenable_ctrl: valid cycles %0d ctrl %h, expected 0 00000000", valid_cycles, rd);
        end
    endtask
`endif

    initial begin
        reset_n    = 1'b0;
        address    = '0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = '0;
        out_ready  = 1'b0;
`ifdef PIO_BYTEENABLE_EN
        be         = 4'b1111;
`endif
        tick(3);
        reset_n = 1'b1;
        tick(1);

        test_reset;
        test_commit;
        test_snapshot_window;
        test_pending;
        test_auto_commit;
        test_ready_same_cycle;
        test_unmapped;
        test_reset_mid;
`ifdef PIO_BYTEENABLE_EN
        test_byteenable;
`endif

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
